mult_stream_ctrl: RTL and testbench
===================================

MULT_STREAM_CTRL -- requirements
Module: mult_stream_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, 8, operand/result width.
REQ-003 Parameter: LAT, 3, rising edges from the multiplier sampling mult_en=1 to mult_out valid.
REQ-004 Parameter: DEPTH, 2, result FIFO entries.
REQ-005 Ports SHALL be, clock and reset first:
 clk  in  1  clock, rising edge
 rst_n  in  1  async active-low reset
 in_valid  in  1  operand pair offered
 in_ready  out  1  operand pair accepted when both high
 in_a  in  WIDTH  operand a
 in_b  in  WIDTH  operand b
 mult_a  out  WIDTH  to multiplier a
 mult_b  out  WIDTH  to multiplier b
 mult_en  out  1  to multiplier en
 mult_out  in  WIDTH  from multiplier out
 out_valid  out  1  result available
 out_ready  in  1  result consumed when both high
 out_data  out  WIDTH  result, a*b*b*b mod 2^WIDTH
 busy  out  1  operation in flight

Function
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT and CAPTURE.
REQ-007 in_ready SHALL be 1 only in IDLE with FIFO count < DEPTH.
REQ-008 On accept: register in_a/in_b to mult_a/mult_b, set mult_en=1, go to ISSUE.
REQ-009 ISSUE: the multiplier samples on the next edge; mult_en SHALL clear, load the counter with LAT-1, go to WAIT.
REQ-010 WAIT: decrement each cycle; at 0 go to CAPTURE. mult_out is valid in CAPTURE.
REQ-011 CAPTURE: push mult_out into the FIFO on the edge, return to IDLE.
REQ-012 Latency: out_valid SHALL rise LAT+1 cycles after the accept edge when the FIFO was empty.
REQ-013 busy SHALL be 1 in ISSUE, WAIT and CAPTURE.
REQ-014 mult_a/mult_b SHALL hold their values until the next accept.
REQ-015 FIFO SHALL be in order.
REQ-016 out_valid = count != 0.
REQ-017 out_data SHALL be the head entry, stable while out_valid && !out_ready.
REQ-018 A push and a pop on the same edge SHALL leave the count unchanged and preserve order.
REQ-019 The FIFO SHALL never overflow, because the issue gating guarantees a free slot at CAPTURE.
REQ-020 Products SHALL wrap modulo 2^WIDTH (multiplier behaviour; no saturation).

Reset
REQ-021 While rst_n=0: state=IDLE, FIFO empty, mult_en=0, mult_a=mult_b=0, out_valid=0, busy=0, counter=0.
REQ-022 Reset mid-operation SHALL discard the in-flight result; no stale push after release.
REQ-023 in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-024 Macro MULT_STREAM_CTRL_PERF_CNT_EN, when defined, SHALL add output op_count[15:0].
REQ-025 op_count is reset to 0, increments on each CAPTURE push, and wraps at 65535->0.
REQ-026 When MULT_STREAM_CTRL_PERF_CNT_EN is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Shared package mult_stream_pkg SHALL hold the FSM state encoding and the WIDTH/LAT/DEPTH defaults.
REQ-028 The FIFO SHALL be sub-module mult_stream_fifo (parameterised WIDTH, DEPTH; push/pop/count/head).
REQ-029 The multiplier SHALL be external; this block only drives and samples its ports.

Verification
REQ-030 Single op: in_a=2, in_b=3, out_ready=1 -> out_data=54, out_valid 4 cycles after accept; in_ready=0 for those 4 cycles.
REQ-031 Backpressure: out_ready=0, send (2,3) then (1,2) -> FIFO holds 54,8; in_ready stays 0; raise out_ready -> 54 then 8.
REQ-032 Wrap: in_a=5, in_b=7 -> out_data=179 (1715 mod 256).
REQ-033 Reset mid-WAIT: rst_n low 1 cycle, 2 cycles after accepting (2,3) -> out_valid never rises; in_ready=1 after release.
REQ-034 Simultaneous push/pop: count=1 holding 54, out_ready=1 at the CAPTURE of (1,2) -> count stays 1, next out_data=8.
REQ-035 With MULT_STREAM_CTRL_PERF_CNT_EN: 3 completed ops -> op_count=3; without the macro the bench compiles with no op_count port.

Source files
------------

// File: rtl/mult_stream_pkg.sv
// Shared types and defaults for the streaming multiplier controller.
// Holds the FSM state encoding, WIDTH/LAT/DEPTH defaults and a width helper.
package mult_stream_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int LAT_DEF   = 3;
    localparam int DEPTH_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE
    } state_e;

    // Bits needed to hold the values 0..n (never less than one bit).
    function automatic int clog2p1(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_stream_fifo.sv
// In-order result FIFO with simultaneous push/pop support.
// Ports: clk, rst_n, push_i/data_i (write), pop_i (read), head_o, count_o.
module mult_stream_fifo
    import mult_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            head_o,
    output logic [clog2p1(DEPTH)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = clog2p1(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        end
        if (pop_i) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        end
        // Push and pop together leave the occupancy unchanged.
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mult_stream_ctrl.sv
// Streaming controller for an external fixed-latency multiplier with result FIFO.
// Ports: clk/rst_n, in_* (operand handshake), mult_* (multiplier side),
// out_* (result handshake), busy. Optional op_count[15:0] when
// MULT_STREAM_CTRL_PERF_CNT_EN is defined.
module mult_stream_ctrl
    import mult_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] mult_a,
    output logic [WIDTH-1:0] mult_b,
    output logic             mult_en,
    input  logic [WIDTH-1:0] mult_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef MULT_STREAM_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    localparam int CNT_W = clog2p1(LAT);
    localparam int CW    = clog2p1(DEPTH);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mult_a_q;
    logic [WIDTH-1:0] mult_b_q;
    logic             mult_en_q;
    logic             busy_q;

    logic             push;
    logic             pop;
    logic [CW-1:0]    fifo_cnt;
    logic [WIDTH-1:0] fifo_head;

    // Only issue when a slot is free: nothing else pushes while in flight,
    // so the CAPTURE push can never overflow.
    assign in_ready  = (state_q == IDLE) && (fifo_cnt < CW'(DEPTH));
    assign push      = (state_q == CAPTURE);
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            mult_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mult_a_q  <= in_a;
                        mult_b_q  <= in_b;
                        mult_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Multiplier samples on this edge; LAT-1 more edges follow.
                    mult_en_q <= 1'b0;
                    cnt_q     <= CNT_W'(LAT - 1);
                    state_q   <= (LAT <= 1) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    // Leave as the count reaches zero so CAPTURE lines up
                    // with the cycle mult_out becomes valid.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mult_a  = mult_a_q;
    assign mult_b  = mult_b_q;
    assign mult_en = mult_en_q;
    assign busy    = busy_q;

    mult_stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (mult_out),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    assign out_data = fifo_head;

`ifdef MULT_STREAM_CTRL_PERF_CNT_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (push) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mult_stream_ctrl.sv
// Self-checking bench for mult_stream_ctrl with a behavioural multiplier.
// Scoreboard queue holds expected results in accept order.
module tb_mult_stream_ctrl;

    localparam int WIDTH = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] mult_a;
    logic [WIDTH-1:0] mult_b;
    logic             mult_en;
    logic [WIDTH-1:0] mult_out;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef MULT_STREAM_CTRL_PERF_CNT_EN
    logic [15:0]      op_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] pipe [LAT];

    mult_stream_ctrl #(
        .WIDTH (WIDTH),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_en   (mult_en),
        .mult_out  (mult_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef MULT_STREAM_CTRL_PERF_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model(input int a, input int b);
        longint p;
        p = longint'(a) * b * b * b;
        return p[WIDTH-1:0];
    endfunction

    // External multiplier: result appears LAT edges after sampling mult_en.
    always @(posedge clk) begin
        pipe[0] <= mult_en ? model(int'(mult_a), int'(mult_b)) : '0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mult_out = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Monitor: inputs change at posedge+1, so negedge shows what the next
    // edge will transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)
                exp_q.push_back(model(int'(in_a), int'(in_b)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexp_out", 32'(out_valid), 0);
                else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accept", 32'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        chk("idle_to", 32'(ok), 1);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !out_valid && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("drain_to", 32'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_men", 32'(mult_en), 0);
        chk("rst_ma", 32'(mult_a), 0);
        chk("rst_mb", 32'(mult_b), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_inrdy", 32'(in_ready), 1);

        // Single op with latency profile
        out_ready = 1'b1;
        send(8'd2, 8'd3);
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk);
            chk("lat_ovalid", 32'(out_valid), 0);
            chk("lat_inrdy", 32'(in_ready), 0);
            chk("lat_busy", 32'(busy), 1);
            chk("lat_men", 32'(mult_en), 32'(i == 0));
        end
        @(negedge clk);
        chk("lat_rise", 32'(out_valid), 1);
        wait_drain();

        // Wrap, and operand hold after completion
        send(8'd5, 8'd7);
        wait_drain();
        chk("hold_a", 32'(mult_a), 5);
        chk("hold_b", 32'(mult_b), 7);

        // Backpressure: two results stacked, head stable
        out_ready = 1'b0;
        send(8'd2, 8'd3);
        send(8'd1, 8'd2);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_inrdy", 32'(in_ready), 0);
            chk("bp_ovalid", 32'(out_valid), 1);
            chk("bp_head", 32'(out_data), 54);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // Push and pop on the same edge
        out_ready = 1'b0;
        send(8'd2, 8'd3);
        wait_idle();
        send(8'd1, 8'd2);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("pp_capture", 32'(busy), 1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("pp_ovalid", 32'(out_valid), 1);
            chk("pp_head", 32'(out_data), 8);
            chk("pp_inrdy", 32'(in_ready), 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pp_empty", 32'(out_valid), 0);
        wait_drain();

        // Reset in WAIT discards the in-flight result
        send(8'd2, 8'd3);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_men", 32'(mult_en), 0);
        chk("mr_ovalid", 32'(out_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mr_inrdy", 32'(in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mr_stale", 32'(out_valid), 0);
        end

        // Random ops after reset
        for (int i = 0; i < 3; i++) begin
            send(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)));
            wait_drain();
        end
`ifdef MULT_STREAM_CTRL_PERF_CNT_EN
        chk("op_count", 32'(op_count), 3);
`endif
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
